unified_mem_arbiter: RTL and testbench

UNIFIED_MEM_ARBITER -- requirements
Module: unified_mem_arbiter

---
 rtl/mem_arb_pkg.sv | 40 ++++
 rtl/mem_lane_align.sv | 57 +++++
 rtl/unified_mem_arbiter.sv | 174 +++++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified instruction/data memory arbiter:
// RV32I size codes, FSM encoding, starvation default and access legality.
package mem_arb_pkg;

  localparam int STARVE_LIMIT_DEF = 4;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ISSUE  = 2'b01,
    ST_WAIT_R = 2'b10
  } arb_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  // Misaligned, reserved, or store-with-unsigned-size accesses are rejected.
  function automatic logic access_illegal(input logic [2:0] funct3,
                                          input logic       we,
                                          input logic [1:0] addr_lo);
    logic ill;
    case (funct3)
      F3_LB:   ill = 1'b0;
      F3_LH:   ill = addr_lo[0];
      F3_LW:   ill = (addr_lo != 2'b00);
      F3_LBU:  ill = we;
      F3_LHU:  ill = we | addr_lo[0];
      default: ill = 1'b1;
    endcase
    return ill;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store strobe/replication and load extract/extend.
module mem_lane_align
  import mem_arb_pkg::*;
(
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_addr_lo,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_wstrb,
  output logic [31:0] st_wdata_rep,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte_s;
  logic [15:0] ld_half_s;

  // Store path: strobe selects lanes, data replicated so any lane carries it.
  always_comb begin
    st_wstrb     = 4'b0000;
    st_wdata_rep = st_wdata;
    case (st_funct3)
      F3_LB: begin
        st_wstrb     = 4'b0001 << st_addr_lo;
        st_wdata_rep = {4{st_wdata[7:0]}};
      end
      F3_LH: begin
        st_wstrb     = st_addr_lo[1] ? 4'b1100 : 4'b0011;
        st_wdata_rep = {2{st_wdata[15:0]}};
      end
      F3_LW:   st_wstrb = 4'b1111;
      default: st_wstrb = 4'b0000;
    endcase
  end

  // Load path: pick the addressed lane, then sign- or zero-extend.
  always_comb begin
    case (ld_addr_lo)
      2'b00:   ld_byte_s = ld_rdata[7:0];
      2'b01:   ld_byte_s = ld_rdata[15:8];
      2'b10:   ld_byte_s = ld_rdata[23:16];
      2'b11:   ld_byte_s = ld_rdata[31:24];
      default: ld_byte_s = 8'h00;
    endcase
    ld_half_s = ld_addr_lo[1] ? ld_rdata[31:16] : ld_rdata[15:0];
    case (ld_funct3)
      F3_LB:   ld_data = {{24{ld_byte_s[7]}}, ld_byte_s};
      F3_LH:   ld_data = {{16{ld_half_s[15]}}, ld_half_s};
      F3_LW:   ld_data = ld_rdata;
      F3_LBU:  ld_data = {24'h000000, ld_byte_s};
      F3_LHU:  ld_data = {16'h0000, ld_half_s};
      default: ld_data = 32'h00000000;
    endcase
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates instruction-fetch and data ports onto one single-outstanding
// memory interface, with D priority bounded by an I-side starvation counter.
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int ADDR_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [2:0]        d_funct3,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  localparam logic [2:0]        LIMIT_C   = 3'(STARVE_LIMIT);
  localparam logic [ADDR_W-1:0] WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

  arb_state_e  state_r, state_nxt_s;
  owner_e      owner_r;
  logic [2:0]  starve_cnt_r;
  logic [2:0]  ld_funct3_r;
  logic [1:0]  ld_addr_lo_r;
  logic        d_ok_s, d_illegal_s;
  logic        grant_i_s, grant_d_s, reject_s, deliver_s;
  logic [3:0]  st_wstrb_s;
  logic [31:0] st_wdata_s, ld_data_s;

  mem_lane_align u_align (
    .st_funct3    (d_funct3),
    .st_addr_lo   (d_addr[1:0]),
    .st_wdata     (d_wdata),
    .st_wstrb     (st_wstrb_s),
    .st_wdata_rep (st_wdata_s),
    .ld_funct3    (ld_funct3_r),
    .ld_addr_lo   (ld_addr_lo_r),
    .ld_rdata     (mem_rdata),
    .ld_data      (ld_data_s)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and arbitration decision; a rejected D request is masked for
  // one cycle so the still-held request is not rejected twice.
  always_comb begin
    state_nxt_s = state_r;
    grant_i_s   = 1'b0;
    grant_d_s   = 1'b0;
    reject_s    = 1'b0;
    deliver_s   = 1'b0;
    d_ok_s      = d_req & ~d_err;
    d_illegal_s = access_illegal(d_funct3, d_we, d_addr[1:0]);
    case (state_r)
      ST_IDLE: begin
        if (i_req && (!d_ok_s || (starve_cnt_r == LIMIT_C))) begin
          grant_i_s   = 1'b1;
          state_nxt_s = ST_ISSUE;
        end else if (d_ok_s && d_illegal_s) begin
          reject_s    = 1'b1;
          state_nxt_s = ST_IDLE;
        end else if (d_ok_s) begin
          grant_d_s   = 1'b1;
          state_nxt_s = ST_ISSUE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (mem_ready) begin
          state_nxt_s = mem_we ? ST_IDLE : ST_WAIT_R;
        end else begin
          state_nxt_s = ST_ISSUE;
        end
      end
      ST_WAIT_R: begin
        if (mem_rvalid) begin
          deliver_s   = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT_R;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Registered outputs, latched request fields and starvation counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_gnt        <= 1'b0;
      i_rvalid     <= 1'b0;
      i_rdata      <= 32'h00000000;
      d_gnt        <= 1'b0;
      d_rvalid     <= 1'b0;
      d_rdata      <= 32'h00000000;
      d_err        <= 1'b0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= {ADDR_W{1'b0}};
      mem_wdata    <= 32'h00000000;
      mem_wstrb    <= 4'b0000;
      owner_r      <= OWN_I;
      starve_cnt_r <= 3'd0;
      ld_funct3_r  <= 3'b000;
      ld_addr_lo_r <= 2'b00;
    end else begin
      i_gnt    <= grant_i_s;
      d_gnt    <= grant_d_s;
      d_err    <= reject_s;
      i_rvalid <= deliver_s && (owner_r == OWN_I);
      d_rvalid <= deliver_s && (owner_r == OWN_D);
      if (grant_i_s) begin
        owner_r      <= OWN_I;
        mem_req      <= 1'b1;
        mem_we       <= 1'b0;
        mem_addr     <= i_addr & WORD_MASK;
        mem_wdata    <= 32'h00000000;
        mem_wstrb    <= 4'b0000;
        starve_cnt_r <= 3'd0;
      end else if (grant_d_s) begin
        owner_r      <= OWN_D;
        mem_req      <= 1'b1;
        mem_we       <= d_we;
        mem_addr     <= d_addr & WORD_MASK;
        mem_wdata    <= d_we ? st_wdata_s : 32'h00000000;
        mem_wstrb    <= d_we ? st_wstrb_s : 4'b0000;
        ld_funct3_r  <= d_funct3;
        ld_addr_lo_r <= d_addr[1:0];
        if (i_req && (starve_cnt_r != LIMIT_C)) begin
          starve_cnt_r <= starve_cnt_r + 3'd1;
        end
      end else if ((state_r == ST_ISSUE) && mem_ready) begin
        mem_req   <= 1'b0;
        mem_we    <= 1'b0;
        mem_addr  <= {ADDR_W{1'b0}};
        mem_wdata <= 32'h00000000;
        mem_wstrb <= 4'b0000;
      end
      if (deliver_s && (owner_r == OWN_I)) begin
        i_rdata <= mem_rdata;
      end
      if (deliver_s && (owner_r == OWN_D)) begin
        d_rdata <= ld_data_s;
      end
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Randomized self-checking bench for unified_mem_arbiter with a byte-level
// reference memory and a randomly-timed memory responder.
module tb_unified_mem_arbiter;

  localparam int LIMIT = 4;
  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;

  logic        clk, reset;
  logic        i_req, i_gnt, i_rvalid;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid, d_err;
  logic [2:0]  d_funct3;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_req, mem_we, mem_ready, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  int n_checks = 0;
  int n_errors = 0;
  int late_req_cnt = 0;
  int gnt_log[$];
  logic [2:0] starve_at_i;
  logic [7:0] ref_b [int unsigned];

  typedef struct packed {
    logic gnt; logic err; logic tmo; logic req; logic we;
    logic [31:0] rdata; logic [31:0] addr; logic [31:0] wdata; logic [3:0] strb;
  } d_res_t;

  unified_mem_arbiter #(.STARVE_LIMIT(LIMIT), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory responder: random accept delay, read data 1..3 cycles after acceptance.
  initial begin
    logic [31:0] mem_arr [int unsigned];
    logic [31:0] rd_word, w;
    int rd_cnt, late_done;
    int unsigned widx;
    mem_arr[32'h100 >> 2] = 32'h80018000;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    rd_cnt = -1; late_done = 0; rd_word = 32'h0;
    forever begin
      @(negedge clk);
      mem_ready = 1'b0;
      mem_rvalid = 1'b0;
      if (reset) begin
        rd_cnt = -1;
      end else begin
        if (late_req_cnt != late_done) begin
          mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF; late_done = late_req_cnt;
        end else if (rd_cnt == 0) begin
          mem_rvalid = 1'b1; mem_rdata = rd_word; rd_cnt = -1;
        end else if (rd_cnt > 0) begin
          rd_cnt = rd_cnt - 1;
        end
        if (mem_req && rd_cnt < 0 && $urandom_range(0, 1) == 1) begin
          mem_ready = 1'b1;
          widx = mem_addr >> 2;
          w = mem_arr.exists(widx) ? mem_arr[widx] : 32'h0;
          if (mem_we) begin
            for (int b = 0; b < 4; b++) if (mem_wstrb[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
            mem_arr[widx] = w;
          end else begin
            rd_word = w;
            rd_cnt = $urandom_range(0, 2);
          end
        end
      end
    end
  end

  // Grant-order monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (i_gnt) begin gnt_log.push_back(0); starve_at_i = dut.starve_cnt_r; end
      if (d_gnt) gnt_log.push_back(1);
    end
  end

  function automatic logic [138:0] all_outs();
    return {i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, d_err,
            mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb};
  endfunction

  function automatic logic [7:0] ref_byte(input logic [31:0] a);
    return ref_b.exists(a) ? ref_b[a] : 8'h00;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [31:0] base = a & 32'hFFFFFFFC;
    return {ref_byte(base + 3), ref_byte(base + 2), ref_byte(base + 1), ref_byte(base)};
  endfunction

  function automatic int acc_size(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    else if (f3[1:0] == 2'b01) return 2;
    else return 4;
  endfunction

  function automatic bit tb_legal(input logic [2:0] f3, input logic we, input logic [31:0] a);
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b0;
    if (we && f3 >= 3'd4) return 1'b0;
    return (a % acc_size(f3)) == 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    int sz = acc_size(f3);
    logic [31:0] v = 32'h0;
    logic [31:0] m;
    for (int i = 0; i < sz; i++) v = v | (32'(ref_byte(a + i)) << (8 * i));
    if (sz < 4 && f3[2] == 1'b0) begin
      m = (32'h1 << (8 * sz)) - 32'h1;
      if (v[8*sz-1]) v = v | ~m;
    end
    return v;
  endfunction

  task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    for (int i = 0; i < acc_size(f3); i++) ref_b[a + i] = wd[8*i +: 8];
  endtask

  task automatic d_access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output d_res_t r);
    r = '0;
    r.tmo = 1'b1;
    d_req = 1'b1; d_we = we; d_funct3 = f3; d_addr = a; d_wdata = wd;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      if (d_gnt || d_err) begin
        r.gnt = d_gnt; r.err = d_err; r.req = mem_req; r.we = mem_we;
        r.addr = mem_addr; r.wdata = mem_wdata; r.strb = mem_wstrb; r.tmo = 1'b0;
        break;
      end
    end
    d_req = 1'b0;
    if (r.gnt && !we) begin
      r.tmo = 1'b1;
      for (int c = 0; c < 300; c++) begin
        @(posedge clk); #1;
        if (d_rvalid) begin r.rdata = d_rdata; r.tmo = 1'b0; break; end
      end
    end
  endtask

  task automatic i_access(input logic [31:0] a, output logic [31:0] rd, output logic tmo);
    tmo = 1'b1; rd = 32'h0;
    i_req = 1'b1; i_addr = a;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      if (i_gnt) begin tmo = 1'b0; break; end
    end
    i_req = 1'b0;
    if (!tmo) begin
      tmo = 1'b1;
      for (int c = 0; c < 300; c++) begin
        @(posedge clk); #1;
        if (i_rvalid) begin rd = i_rdata; tmo = 1'b0; break; end
      end
    end
  endtask

  task automatic settle();
    for (int c = 0; c < 300; c++) begin
      if (!mem_req) break;
      @(posedge clk); #1;
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (all_outs() !== 139'd0) begin
      n_errors++; $display("FAIL reset_outputs: got %h expected 0", all_outs());
    end
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (all_outs() !== 139'd0 || dut.starve_cnt_r !== 3'd0) begin
      n_errors++; $display("FAIL idle_after_reset: got %h starve %0d expected 0", all_outs(), dut.starve_cnt_r);
    end
  endtask

  task automatic test_arbitration();
    d_res_t dr;
    logic [31:0] ird;
    logic itmo;
    int base = gnt_log.size();
    fork
      d_access(1'b0, LW, 32'h100, 32'h0, dr);
      i_access(32'h40, ird, itmo);
    join
    n_checks++;
    if (dr.tmo || itmo || gnt_log.size() < base + 2) begin
      n_errors++; $display("FAIL arb_complete: got dtmo %0b itmo %0b grants %0d expected 0 0 2", dr.tmo, itmo, gnt_log.size() - base);
    end else begin
      n_checks++;
      if (gnt_log[base] != 1 || gnt_log[base+1] != 0) begin
        n_errors++; $display("FAIL arb_order: got %0d,%0d expected 1,0 (D then I)", gnt_log[base], gnt_log[base+1]);
      end
    end
    n_checks++;
    if (dr.addr !== 32'h100 || dr.strb !== 4'b0000 || dr.we !== 1'b0) begin
      n_errors++; $display("FAIL arb_mem_fields: got addr %h strb %b we %b expected 100 0000 0", dr.addr, dr.strb, dr.we);
    end
    n_checks++;
    if (dr.rdata !== 32'h80018000) begin
      n_errors++; $display("FAIL arb_lw_data: got %h expected 80018000", dr.rdata);
    end
    n_checks++;
    if (ird !== ref_word(32'h40)) begin
      n_errors++; $display("FAIL arb_fetch_data: got %h expected %h", ird, ref_word(32'h40));
    end
  endtask

  task automatic test_store_sb();
    d_res_t r;
    d_access(1'b1, LB, 32'h203, 32'h000000A5, r);
    ref_store(LB, 32'h203, 32'h000000A5);
    n_checks++;
    if (r.gnt !== 1'b1 || r.addr !== 32'h200 || r.strb !== 4'b1000 || r.wdata !== 32'hA5A5A5A5 || r.we !== 1'b1) begin
      n_errors++; $display("FAIL sb_fields: got gnt %b addr %h strb %b wdata %h we %b expected 1 200 1000 a5a5a5a5 1",
                           r.gnt, r.addr, r.strb, r.wdata, r.we);
    end
    settle();
    d_access(1'b0, LW, 32'h200, 32'h0, r);
    n_checks++;
    if (r.tmo || r.rdata !== 32'hA5000000) begin
      n_errors++; $display("FAIL sb_readback: got %h tmo %b expected a5000000", r.rdata, r.tmo);
    end
  endtask

  task automatic test_load_extend();
    logic [2:0]  f3s [6] = '{LB, LB, LBU, LH, LHU, LW};
    logic [31:0] as  [6] = '{32'h102, 32'h101, 32'h101, 32'h102, 32'h102, 32'h100};
    logic [31:0] exs [6] = '{32'h00000001, 32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h00008001, 32'h80018000};
    d_res_t r;
    for (int k = 0; k < 6; k++) begin
      d_access(1'b0, f3s[k], as[k], 32'h0, r);
      n_checks++;
      if (r.tmo || r.rdata !== exs[k]) begin
        n_errors++; $display("FAIL load_ext_%0d: got %h tmo %b expected %h", k, r.rdata, r.tmo, exs[k]);
      end
    end
  endtask

  task automatic test_errors();
    logic [2:0]  f3s [6] = '{LW, 3'b011, LH, LBU, 3'b110, 3'b111};
    logic        wes [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] as  [6] = '{32'h102, 32'h100, 32'h101, 32'h104, 32'h100, 32'h100};
    d_res_t r;
    for (int k = 0; k < 6; k++) begin
      d_access(wes[k], f3s[k], as[k], 32'h12345678, r);
      @(posedge clk); #1;
      n_checks++;
      if (r.err !== 1'b1 || r.gnt !== 1'b0 || r.req !== 1'b0 || mem_req !== 1'b0) begin
        n_errors++; $display("FAIL reject_%0d: got err %b gnt %b mem_req %b/%b expected 1 0 0/0", k, r.err, r.gnt, r.req, mem_req);
      end
    end
  endtask

  task automatic test_starvation();
    d_res_t dr;
    logic [31:0] ird;
    logic itmo;
    int base;
    apply_reset();
    base = gnt_log.size();
    fork
      begin
        for (int k = 0; k < 6; k++) d_access(1'b0, LW, 32'h100, 32'h0, dr);
      end
      i_access(32'h200, ird, itmo);
    join
    for (int k = 0; k <= LIMIT; k++) begin
      n_checks++;
      if (gnt_log.size() <= base + k) begin
        n_errors++; $display("FAIL starve_order_%0d: got no grant expected a grant", k);
      end else if (gnt_log[base+k] != ((k < LIMIT) ? 1 : 0)) begin
        n_errors++; $display("FAIL starve_order_%0d: got %0d expected %0d", k, gnt_log[base+k], (k < LIMIT) ? 1 : 0);
      end
    end
    n_checks++;
    if (starve_at_i !== 3'd0) begin
      n_errors++; $display("FAIL starve_clear: got %0d expected 0", starve_at_i);
    end
    n_checks++;
    if (itmo || ird !== ref_word(32'h200) || dr.rdata !== 32'h80018000) begin
      n_errors++; $display("FAIL starve_data: got i %h d %h expected %h 80018000", ird, dr.rdata, ref_word(32'h200));
    end
  endtask

  task automatic test_reset_wait_r();
    d_res_t r;
    logic ok = 1'b0;
    int seen = 0;
    d_req = 1'b1; d_we = 1'b0; d_funct3 = LW; d_addr = 32'h100; d_wdata = 32'h0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      if (d_gnt) begin ok = 1'b1; break; end
    end
    d_req = 1'b0;
    for (int c = 0; c < 300 && ok; c++) begin
      @(posedge clk); #1;
      if (!mem_req) break;
    end
    n_checks++;
    if (!ok || mem_req !== 1'b0 || d_rvalid !== 1'b0) begin
      n_errors++; $display("FAIL rst_reach_wait: got gnt %b mem_req %b rvalid %b expected 1 0 0", ok, mem_req, d_rvalid);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (all_outs() !== 139'd0 || dut.starve_cnt_r !== 3'd0) begin
      n_errors++; $display("FAIL rst_in_wait_outputs: got %h expected 0", all_outs());
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    late_req_cnt = late_req_cnt + 1;
    repeat (5) begin
      @(posedge clk); #1;
      if (d_rvalid || i_rvalid) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_errors++; $display("FAIL late_rvalid_ignored: got %0d pulses expected 0", seen);
    end
    d_access(1'b0, LW, 32'h100, 32'h0, r);
    n_checks++;
    if (r.tmo || r.rdata !== 32'h80018000) begin
      n_errors++; $display("FAIL lw_after_reset: got %h tmo %b expected 80018000", r.rdata, r.tmo);
    end
  endtask

  task automatic test_random();
    d_res_t r;
    logic [31:0] a, wd, ird, exp;
    logic [2:0] f3;
    logic we, itmo;
    int sz;
    for (int n = 0; n < 60; n++) begin
      a = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) begin
        i_access(a, ird, itmo);
        n_checks++;
        if (itmo || ird !== ref_word(a)) begin
          n_errors++; $display("FAIL rnd_fetch_%0d: got %h expected %h", n, ird, ref_word(a));
        end
      end else begin
        f3 = 3'($urandom_range(0, 7));
        we = 1'($urandom_range(0, 1));
        wd = $urandom;
        sz = acc_size(f3);
        exp = ref_load(f3, a);
        d_access(we, f3, a, wd, r);
        n_checks++;
        if (!tb_legal(f3, we, a)) begin
          if (r.err !== 1'b1 || r.gnt !== 1'b0) begin
            n_errors++; $display("FAIL rnd_reject_%0d: got err %b gnt %b expected 1 0", n, r.err, r.gnt);
          end
        end else if (we) begin
          ref_store(f3, a, wd);
          if (r.gnt !== 1'b1 || r.addr !== (a & 32'hFFFFFFFC) || r.strb !== 4'(((1 << sz) - 1) << (a % 4))) begin
            n_errors++; $display("FAIL rnd_store_%0d: got gnt %b addr %h strb %b expected 1 %h %b", n, r.gnt, r.addr,
                                 r.strb, a & 32'hFFFFFFFC, 4'(((1 << sz) - 1) << (a % 4)));
          end
          settle();
        end else begin
          if (r.tmo || r.gnt !== 1'b1 || r.rdata !== exp) begin
            n_errors++; $display("FAIL rnd_load_%0d: got %h expected %h (f3 %0d addr %h)", n, r.rdata, exp, f3, a);
          end
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    i_req = 1'b0; i_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_funct3 = 3'b000; d_addr = 32'h0; d_wdata = 32'h0;
    ref_store(LW, 32'h100, 32'h80018000);
    test_reset();
    test_arbitration();
    settle();
    test_store_sb();
    settle();
    test_load_extend();
    test_errors();
    test_starvation();
    test_reset_wait_r();
    settle();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
